// File: rtl/opcode_decoder_reg.sv
// opcode_decoder_reg: registered one-hot decoder behind a valid/ready stage with out-of-range flag.
// Define DEC_ERR_CNT_EN to build the saturating illegal-code counter on err_cnt.
module opcode_decoder_reg #(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OUT-1:0] out,
  output logic               out_err,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   err_cnt
);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;
  localparam logic [SEL_W:0] LP_NUM = (SEL_W+1)'(NUM_OUT);
  logic [0:0]         r_state;
  logic [NUM_OUT-1:0] r_out;
  logic               r_err;
  logic               w_accept;
  logic               w_illegal;
  logic [NUM_OUT-1:0] w_out_nxt;
  assign out_valid = (r_state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign out       = r_out;
  assign out_err   = r_err;
  // An illegal code decodes to zero; the one-hot shift is masked explicitly.
  always_comb begin
    w_illegal = en && ({1'b0, sel} >= LP_NUM);
    w_out_nxt = (en && !w_illegal) ? (NUM_OUT'(1) << sel) : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_out   <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_state <= FULL;
      r_out   <= w_out_nxt;
      r_err   <= w_illegal;
    end else if (out_ready) begin
      r_state <= EMPTY;
    end
  end
`ifdef DEC_ERR_CNT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             w_bump;
  assign w_bump  = w_accept && w_illegal;
  assign err_cnt = r_cnt;
  // Clear takes priority, then the same-cycle illegal accept is counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (cnt_clr) r_cnt <= w_bump ? CNT_W'(1) : '0;
    else if (w_bump && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
  end
`else
  logic w_unused;
  assign w_unused = cnt_clr;
  assign err_cnt  = '0;
`endif
endmodule

// File: tb/tb_opcode_decoder_reg.sv
// tb_opcode_decoder_reg: randomized and directed checks of two decoders (NUM_OUT=8 and NUM_OUT=5).
module tb_opcode_decoder_reg;
  localparam int CNT_ON = `ifdef DEC_ERR_CNT_EN 1 `else 0 `endif;
  localparam int CMAX = 255;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, in_valid = 1'b0, out_ready = 1'b0, cnt_clr = 1'b0;
  logic [2:0] sel = '0;
  logic ir0, ov0, oe0, ir1, ov1, oe1;
  logic [7:0] out0, cnt0, cnt1;
  logic [4:0] out1;
  int checks = 0;
  int errors = 0;
  int nout[2] = '{8, 5};
  bit mv[2];
  int mo[2];
  bit me[2];
  int mc[2];

  always #5 clk = ~clk;

  opcode_decoder_reg #(.SEL_W(3), .NUM_OUT(8), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(ir0),
    .sel(sel), .out_valid(ov0), .out_ready(out_ready), .out(out0),
    .out_err(oe0), .cnt_clr(cnt_clr), .err_cnt(cnt0));

  opcode_decoder_reg #(.SEL_W(3), .NUM_OUT(5), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(ir1),
    .sel(sel), .out_valid(ov1), .out_ready(out_ready), .out(out1),
    .out_err(oe1), .cnt_clr(cnt_clr), .err_cnt(cnt1));

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mv[k] = 0; mo[k] = 0; me[k] = 0; mc[k] = 0;
    end
  endtask

  // Advance one clock: compute each model's next beat from the rules, then land on the next falling edge.
  task automatic cycle();
    bit nv[2]; int no[2]; bit ne[2]; int nc[2];
    for (int k = 0; k < 2; k++) begin
      bit acc, bad;
      acc = in_valid && (!mv[k] || out_ready);
      bad = en && (int'(sel) >= nout[k]);
      nv[k] = acc ? 1'b1 : (out_ready ? 1'b0 : mv[k]);
      no[k] = acc ? ((en && !bad) ? (1 << sel) : 0) : mo[k];
      ne[k] = acc ? bad : me[k];
      nc[k] = cnt_clr ? 0 : mc[k];
      if (acc && bad && nc[k] < CMAX) nc[k]++;
      if (CNT_ON == 0) nc[k] = 0;
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      mv[k] = nv[k]; mo[k] = no[k]; me[k] = ne[k]; mc[k] = nc[k];
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", ov0); end
    checks++; if (out0 !== 8'h00) begin errors++; $display("FAIL rst_out got=%h exp=00", out0); end
    checks++; if (oe0 !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", oe0); end
    checks++; if (cnt0 !== 8'h00) begin errors++; $display("FAIL rst_cnt got=%h exp=00", cnt0); end
    checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", ir0); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    en = 1; out_ready = 1; in_valid = 1;
    for (int s = 0; s < 8; s++) begin
      logic [7:0] e;
      sel = 3'(s);
      cycle();
      e = 8'h01 << s;
      checks++; if (out0 !== e || ov0 !== 1'b1) begin errors++; $display("FAIL sweep_out sel=%0d got=%h/%b exp=%h/1", s, out0, ov0, e); end
      checks++; if (oe0 !== 1'b0) begin errors++; $display("FAIL sweep_err sel=%0d got=%b exp=0", s, oe0); end
      checks++; if (oe1 !== me[1] || out1 !== 5'(mo[1])) begin errors++; $display("FAIL sweep5 sel=%0d got=%h/%b exp=%h/%b", s, out1, oe1, 5'(mo[1]), me[1]); end
    end
    in_valid = 0;
    cycle();
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL sweep_drain got=%b exp=0", ov0); end
  endtask

  task automatic test_disable();
    int c1;
    c1 = mc[1];
    en = 0; sel = 3'd5; in_valid = 1; out_ready = 1;
    cycle();
    checks++; if (ov0 !== 1'b1 || out0 !== 8'h00 || oe0 !== 1'b0) begin errors++; $display("FAIL dis_beat got=%b/%h/%b exp=1/00/0", ov0, out0, oe0); end
    checks++; if (oe1 !== 1'b0 || cnt1 !== 8'(c1)) begin errors++; $display("FAIL dis_cnt got=%b/%0d exp=0/%0d", oe1, cnt1, c1); end
    in_valid = 0;
    cycle();
  endtask

  task automatic test_backpressure();
    en = 1; in_valid = 1; sel = 3'd2; out_ready = 1;
    cycle();
    checks++; if (out0 !== 8'h04) begin errors++; $display("FAIL bp_first got=%h exp=04", out0); end
    out_ready = 0; sel = 3'd6;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (ir0 !== 1'b0) begin errors++; $display("FAIL bp_ready cyc=%0d got=%b exp=0", i, ir0); end
      cycle();
      checks++; if (out0 !== 8'h04 || ov0 !== 1'b1) begin errors++; $display("FAIL bp_hold cyc=%0d got=%h/%b exp=04/1", i, out0, ov0); end
    end
    out_ready = 1;
    #1;
    checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL bp_release got=%b exp=1", ir0); end
    cycle();
    checks++; if (out0 !== 8'h40 || ov0 !== 1'b1) begin errors++; $display("FAIL bp_next got=%h/%b exp=40/1", out0, ov0); end
    in_valid = 0;
    cycle();
  endtask

  task automatic test_illegal();
    cnt_clr = 1; in_valid = 0; out_ready = 1;
    cycle();
    cnt_clr = 0; en = 1; sel = 3'd6; in_valid = 1;
    cycle();
    checks++; if (out1 !== 5'b00000 || oe1 !== 1'b1) begin errors++; $display("FAIL ill_beat got=%b/%b exp=00000/1", out1, oe1); end
    checks++; if (cnt1 !== 8'(CNT_ON)) begin errors++; $display("FAIL ill_cnt1 got=%0d exp=%0d", cnt1, CNT_ON); end
    checks++; if (oe0 !== 1'b0 || cnt0 !== 8'h00) begin errors++; $display("FAIL ill_full_range got=%b/%0d exp=0/0", oe0, cnt0); end
    for (int i = 0; i < 300; i++) cycle();
    checks++; if (cnt1 !== 8'(CNT_ON * 255)) begin errors++; $display("FAIL ill_sat got=%0d exp=%0d", cnt1, CNT_ON * 255); end
    cnt_clr = 1;
    cycle();
    cnt_clr = 0;
    checks++; if (cnt1 !== 8'(CNT_ON)) begin errors++; $display("FAIL ill_clr_bump got=%0d exp=%0d", cnt1, CNT_ON); end
    in_valid = 0;
    cycle();
  endtask

  task automatic test_reset_mid();
    en = 1; sel = 3'd4; in_valid = 1; out_ready = 1;
    cycle();
    in_valid = 0; out_ready = 0;
    cycle();
    checks++; if (out0 !== 8'h10 || ov0 !== 1'b1) begin errors++; $display("FAIL mid_pre got=%h/%b exp=10/1", out0, ov0); end
    #2 rst_n = 0;
    #1;
    checks++; if (ov0 !== 1'b0 || out0 !== 8'h00 || oe0 !== 1'b0) begin errors++; $display("FAIL mid_rst got=%b/%h/%b exp=0/00/0", ov0, out0, oe0); end
    checks++; if (cnt0 !== 8'h00 || cnt1 !== 8'h00 || ov1 !== 1'b0) begin errors++; $display("FAIL mid_rst_cnt got=%0d/%0d/%b exp=0/0/0", cnt0, cnt1, ov1); end
    model_reset();
    #1 rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 7) != 0);
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      cnt_clr = $urandom_range(0, 15) == 0;
      sel = 3'($urandom_range(0, 7));
      #1;
      checks++; if (ir0 !== (!mv[0] || out_ready) || ir1 !== (!mv[1] || out_ready)) begin errors++; $display("FAIL rnd_ready i=%0d got=%b%b", i, ir0, ir1); end
      cycle();
      checks++; if (ov0 !== mv[0] || (mv[0] && (out0 !== 8'(mo[0]) || oe0 !== me[0]))) begin errors++; $display("FAIL rnd_d8 i=%0d got=%b/%h/%b exp=%b/%h/%b", i, ov0, out0, oe0, mv[0], 8'(mo[0]), me[0]); end
      checks++; if (ov1 !== mv[1] || (mv[1] && (out1 !== 5'(mo[1]) || oe1 !== me[1]))) begin errors++; $display("FAIL rnd_d5 i=%0d got=%b/%h/%b exp=%b/%h/%b", i, ov1, out1, oe1, mv[1], 5'(mo[1]), me[1]); end
      checks++; if (cnt0 !== 8'(mc[0]) || cnt1 !== 8'(mc[1])) begin errors++; $display("FAIL rnd_cnt i=%0d got=%0d/%0d exp=%0d/%0d", i, cnt0, cnt1, mc[0], mc[1]); end
    end
    cnt_clr = 0; in_valid = 0;
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_disable();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/opcode_decoder_reg.md
# opcode_decoder_reg

Registered, parametrised successor to the team's 3-to-8 opcode decoder: converts a SEL_W-bit select code into a NUM_OUT-wide one-hot word behind a valid/ready handshake with one output register stage. Sits between instruction fetch and the execute-unit enables, and supports stalls from the consumer. Out-of-range codes are flagged rather than silently decoding to zero. An optional saturating counter tallies out-of-range codes for debug.

## Interface
- SEL_W, 3, select code width; legal range 1..6
- NUM_OUT, 8, one-hot output width; 2 <= NUM_OUT <= 2**SEL_W
- CNT_W, 8, width of the illegal-code counter
- clk  input  1  rising-edge clock; the block's only clock
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  decode enable, sampled on the accepting edge
- in_valid  input  1  sel is valid
- in_ready  output  1  block can accept this cycle
- sel  input  SEL_W  select code
- out_valid  output  1  out/out_err hold a valid beat
- out_ready  input  1  consumer takes the beat this cycle
- out  output  NUM_OUT  registered one-hot (or zero) result
- out_err  output  1  registered out-of-range flag for the beat
- cnt_clr  input  1  synchronous clear of err_cnt
- err_cnt  output  CNT_W  saturating count of accepted illegal codes

## Operation
- Output stage states:
  - EMPTY: out_valid = 0.
  - FULL: out_valid = 1.
- in_ready = !out_valid || out_ready. This is combinational and allows full throughput.
- Accept = in_valid && in_ready. On accept the stage goes to FULL and loads the beat as follows:
  - en = 0: out = 0, out_err = 0.
  - en = 1 and sel < NUM_OUT: out = one-hot with bit[sel] = 1, out_err = 0.
  - en = 1 and sel >= NUM_OUT: out = 0, out_err = 1.
- FULL && out_ready && !accept: the stage goes to EMPTY.
  - out and out_err keep their last values.
  - Consumers must qualify out and out_err with out_valid.
- FULL && !out_ready: out, out_err and out_valid hold unchanged.
  - sel and en changes are ignored while in this state.
- Simultaneous drain and accept (FULL, out_ready = 1, in_valid = 1): the new beat is loaded and out_valid stays 1.
- err_cnt increments by 1 on each accept with en = 1 and sel >= NUM_OUT.
  - It saturates at 2**CNT_W-1 and never wraps.
- cnt_clr = 1 forces err_cnt to 0 on the next edge.
  - If an illegal accept happens in the same cycle, err_cnt loads 1; the clear is applied first, then the event is counted.
- If NUM_OUT == 2**SEL_W, no code is illegal: out_err and err_cnt stay 0.

## Timing
- Latency: sel to out is 1 cycle. A beat accepted at edge N is visible after edge N.
- Throughput: 1 beat per cycle while out_ready = 1.
- Reset (rst_n = 0, asynchronous assert): out_valid = 0, out = 0, out_err = 0, err_cnt = 0.
  - in_ready reads 1 during reset.
- Reset deassertion is synchronised externally. The first accept can occur on the first edge with rst_n = 1.
- Reset asserted while FULL: the pending beat is discarded and is not replayed.
- All outputs except in_ready are registered.

## Configuration
- DEC_ERR_CNT_EN defined:
  - The err_cnt register and its saturate/clear logic are compiled in, as described above.
- DEC_ERR_CNT_EN undefined:
  - err_cnt is tied to 0 and cnt_clr is ignored.
  - out_err behaviour and all handshake behaviour are unchanged.
  - Port list is identical in both builds.

## Test plan
- Sweep, defaults, en = 1, out_ready = 1: sel = 0..7, one per cycle → out = 8'h01, 8'h02, … 8'h80 on consecutive cycles, each one cycle after its accept; out_err = 0 throughout.
- Disable, defaults: en = 0, sel = 3'd5, in_valid = 1 → out_valid = 1, out = 8'h00, out_err = 0; err_cnt unchanged.
- Backpressure: accept sel = 2, hold out_ready = 0 for 4 cycles while driving sel = 6 →
  - out stays 8'h04 and in_ready = 0 throughout.
  - When out_ready rises: the sel = 6 beat is accepted on that same edge and out becomes 8'h40 on the next cycle.
- Illegal code, NUM_OUT = 5, SEL_W = 3, with DEC_ERR_CNT_EN: sel = 3'd6 →
  - out = 5'b00000, out_err = 1, err_cnt = 1.
  - 300 further illegal accepts with CNT_W = 8 → err_cnt = 255.
  - cnt_clr plus an illegal accept in the same cycle → err_cnt = 1.
- Reset mid-beat: FULL with out = 8'h10 and out_ready = 0, pulse rst_n low between edges → out_valid, out, out_err and err_cnt go to 0 immediately, without a clock edge.
- Build without DEC_ERR_CNT_EN: repeat the illegal-code scenario → out_err = 1 as before, err_cnt = 0 throughout.
